// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operator codes, opcode/funct encodings, instruction
// field positions and the immediate extension helper.
package cpu_pkg;

    typedef enum logic [5:0] {
        OP_ADD     = 6'd0,
        OP_ADDI    = 6'd1,
        OP_SUB     = 6'd2,
        OP_SLL     = 6'd3,
        OP_SRL     = 6'd4,
        OP_MUL     = 6'd5,
        OP_LW      = 6'd6,
        OP_SW      = 6'd7,
        OP_BNE     = 6'd8,
        OP_LI      = 6'd9,
        OP_ILLEGAL = 6'b111111
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_MUL   = 6'b011100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_LI    = 6'b110000;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_MUL = 6'b000010;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned SH_MSB  = 10;
    localparam int unsigned SH_LSB  = 6;
    localparam int unsigned FN_MSB  = 5;
    localparam int unsigned FN_LSB  = 0;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    function automatic logic [31:0] ext_imm(input logic [15:0] v, input logic sext);
        return sext ? {{16{v[15]}}, v} : {16'h0000, v};
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction decoder: splits a raw word into operator code,
// register numbers, usage flags and extended immediate.
module instr_field_decode
    import cpu_pkg::*;
#(
    parameter int SIGN_EXT = 1
) (
    input  logic [31:0] instr,
    output logic [5:0]  operatorType,
    output logic [4:0]  reg1,
    output logic [4:0]  reg2,
    output logic [4:0]  destreg,
    output logic [1:0]  src_used,
    output logic        dest_used,
    output logic [31:0] imm
);

    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [31:0] imm_ext;
    op_e         op;

    assign opc     = instr[OPC_MSB:OPC_LSB];
    assign fn      = instr[FN_MSB:FN_LSB];
    assign rs      = instr[RS_MSB:RS_LSB];
    assign rt      = instr[RT_MSB:RT_LSB];
    assign rd      = instr[RD_MSB:RD_LSB];
    assign sh      = instr[SH_MSB:SH_LSB];
    assign imm_ext = ext_imm(instr[IMM_MSB:IMM_LSB], SIGN_EXT != 0);

    always_comb begin
        op        = OP_ILLEGAL;
        reg1      = '0;
        reg2      = '0;
        destreg   = '0;
        src_used  = 2'b00;
        dest_used = 1'b0;
        imm       = '0;
        case (opc)
            OPC_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB: begin
                        op        = (fn == FN_ADD) ? OP_ADD : OP_SUB;
                        reg1      = rs;
                        reg2      = rt;
                        destreg   = rd;
                        src_used  = 2'b11;
                        dest_used = 1'b1;
                    end
                    FN_SLL, FN_SRL: begin
                        // shifts read rt as their only source; shamt is the immediate
                        op        = (fn == FN_SLL) ? OP_SLL : OP_SRL;
                        reg1      = rt;
                        destreg   = rd;
                        src_used  = 2'b01;
                        dest_used = 1'b1;
                        imm       = {27'd0, sh};
                    end
                    default: ;
                endcase
            end
            OPC_MUL: begin
                if (fn == FN_MUL) begin
                    op        = OP_MUL;
                    reg1      = rs;
                    reg2      = rt;
                    destreg   = rd;
                    src_used  = 2'b11;
                    dest_used = 1'b1;
                end
            end
            OPC_ADDI, OPC_LW: begin
                op        = (opc == OPC_ADDI) ? OP_ADDI : OP_LW;
                destreg   = rs;
                reg1      = rt;
                src_used  = 2'b01;
                dest_used = 1'b1;
                imm       = imm_ext;
            end
            OPC_LI: begin
                // li reads no register, so its source field stays zero
                op        = OP_LI;
                destreg   = rs;
                dest_used = 1'b1;
                imm       = imm_ext;
            end
            OPC_SW, OPC_BNE: begin
                op       = (opc == OPC_SW) ? OP_SW : OP_BNE;
                reg1     = rs;
                reg2     = rt;
                src_used = 2'b11;
                imm      = imm_ext;
            end
            default: ;
        endcase
    end

    assign operatorType = op;

endmodule

// File: rtl/instr_issue_queue.sv
// Circular instruction FIFO between fetch and issue, presenting the decoded
// head entry and counting back-pressured issue cycles.
module instr_issue_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int SIGN_EXT = 1,
    parameter int CNTW     = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_instr,
    output logic                       fetch_ready,
    input  logic                       flush,
    input  logic                       issue_ready,
    output logic                       issue_valid,
    output logic [5:0]                 operatorType,
    output logic [4:0]                 reg1,
    output logic [4:0]                 reg2,
    output logic [4:0]                 destreg,
    output logic [1:0]                 src_used,
    output logic                       dest_used,
    output logic [31:0]                imm,
    output logic [31:0]                instr_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNTW-1:0]            stall_cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CNTW-1:0] stall_q;
    logic          push;
    logic          pop;

    assign fetch_ready = ~reset & (count_q < CW'(DEPTH));
    assign issue_valid = ~reset & ~flush & (count_q != '0);
    assign push        = fetch_valid & fetch_ready;
    assign pop         = issue_valid & issue_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= fetch_instr;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (issue_valid && !issue_ready && !(&stall_q)) begin
            stall_q <= stall_q + CNTW'(1);
        end
    end

    assign instr_out    = mem[rd_ptr];
    assign count        = count_q;
    assign stall_cycles = stall_q;

    instr_field_decode #(
        .SIGN_EXT(SIGN_EXT)
    ) u_decode (
        .instr       (instr_out),
        .operatorType(operatorType),
        .reg1        (reg1),
        .reg2        (reg2),
        .destreg     (destreg),
        .src_used    (src_used),
        .dest_used   (dest_used),
        .imm         (imm)
    );

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue; a zero-extending twin shares all inputs.
module tb_instr_issue_queue;

    localparam int DEPTH = 4;
    localparam int CNTW  = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            fetch_valid = 1'b0;
    logic [31:0]     fetch_instr = '0;
    logic            flush = 1'b0;
    logic            issue_ready = 1'b0;

    logic            fetch_ready, issue_valid, dest_used;
    logic [5:0]      operatorType;
    logic [4:0]      reg1, reg2, destreg;
    logic [1:0]      src_used;
    logic [31:0]     imm, instr_out;
    logic [CW-1:0]   count;
    logic [CNTW-1:0] stall_cycles;

    logic            fetch_ready_z, issue_valid_z, dest_used_z;
    logic [5:0]      operatorType_z;
    logic [4:0]      reg1_z, reg2_z, destreg_z;
    logic [1:0]      src_used_z;
    logic [31:0]     imm_z, instr_out_z;
    logic [CW-1:0]   count_z;
    logic [CNTW-1:0] stall_cycles_z;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    instr_issue_queue #(.DEPTH(DEPTH), .SIGN_EXT(1), .CNTW(CNTW)) dut (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_ready(fetch_ready), .flush(flush),
        .issue_ready(issue_ready), .issue_valid(issue_valid),
        .operatorType(operatorType), .reg1(reg1), .reg2(reg2),
        .destreg(destreg), .src_used(src_used), .dest_used(dest_used),
        .imm(imm), .instr_out(instr_out), .count(count),
        .stall_cycles(stall_cycles)
    );

    instr_issue_queue #(.DEPTH(DEPTH), .SIGN_EXT(0), .CNTW(CNTW)) dut_z (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_ready(fetch_ready_z), .flush(flush),
        .issue_ready(issue_ready), .issue_valid(issue_valid_z),
        .operatorType(operatorType_z), .reg1(reg1_z), .reg2(reg2_z),
        .destreg(destreg_z), .src_used(src_used_z), .dest_used(dest_used_z),
        .imm(imm_z), .instr_out(instr_out_z), .count(count_z),
        .stall_cycles(stall_cycles_z)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fetch_valid = 1'b0;
        flush = 1'b0;
        issue_ready = 1'b0;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fetch_valid = 1'b1;
        fetch_instr = 32'h00430820;
        step();
        step();
        checks++;
        if ({count, stall_cycles, issue_valid, fetch_ready} !== {3'd0, 4'd0, 1'b0, 1'b0})
            $display("FAIL reset_state got cnt=%0d stall=%0d iv=%b fr=%b want 0 0 0 0",
                     count, stall_cycles, issue_valid, fetch_ready);
        else passed++;
        fetch_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) $display("FAIL reset_release fetch_ready got %b want 1", fetch_ready);
        else passed++;
    endtask

    task automatic test_add();
        do_reset();
        fetch_valid = 1'b1;
        fetch_instr = 32'h00430820;
        issue_ready = 1'b1;
        #1;
        checks++;
        if (issue_valid !== 1'b0) $display("FAIL add_no_bypass issue_valid got %b want 0", issue_valid);
        else passed++;
        step();
        fetch_valid = 1'b0;
        #1;
        checks++;
        if ({issue_valid, operatorType, reg1, reg2, destreg, src_used, dest_used, count} !==
            {1'b1, 6'd0, 5'd2, 5'd3, 5'd1, 2'b11, 1'b1, 3'd1})
            $display("FAIL add_decode got iv=%b op=%0d r1=%0d r2=%0d d=%0d su=%b du=%b cnt=%0d want 1 0 2 3 1 11 1 1",
                     issue_valid, operatorType, reg1, reg2, destreg, src_used, dest_used, count);
        else passed++;
        step();
        checks++;
        if ({count, issue_valid} !== {3'd0, 1'b0})
            $display("FAIL add_pop got cnt=%0d iv=%b want 0 0", count, issue_valid);
        else passed++;
        issue_ready = 1'b0;
    endtask

    task automatic test_decode();
        logic [31:0] w   [12];
        logic [23:0] exf [12];
        logic [31:0] ims [12];
        logic [31:0] imz [12];
        logic [23:0] got;
        //            word            op     r1     r2     d      su     du
        w[0]  = 32'h00853022; exf[0]  = {6'd2,  5'd4, 5'd5, 5'd6,  2'b11, 1'b1}; ims[0]  = 32'h0;        imz[0]  = 32'h0;
        w[1]  = 32'h000740C0; exf[1]  = {6'd3,  5'd7, 5'd0, 5'd8,  2'b01, 1'b1}; ims[1]  = 32'd3;        imz[1]  = 32'd3;
        w[2]  = 32'h000957C2; exf[2]  = {6'd4,  5'd9, 5'd0, 5'd10, 2'b01, 1'b1}; ims[2]  = 32'd31;       imz[2]  = 32'd31;
        w[3]  = 32'h70221802; exf[3]  = {6'd5,  5'd1, 5'd2, 5'd3,  2'b11, 1'b1}; ims[3]  = 32'h0;        imz[3]  = 32'h0;
        w[4]  = 32'h20A68000; exf[4]  = {6'd1,  5'd6, 5'd0, 5'd5,  2'b01, 1'b1}; ims[4]  = 32'hFFFF8000; imz[4]  = 32'h00008000;
        w[5]  = 32'h8C22FFFC; exf[5]  = {6'd6,  5'd2, 5'd0, 5'd1,  2'b01, 1'b1}; ims[5]  = 32'hFFFFFFFC; imz[5]  = 32'h0000FFFC;
        w[6]  = 32'hAC640010; exf[6]  = {6'd7,  5'd3, 5'd4, 5'd0,  2'b11, 1'b0}; ims[6]  = 32'h10;       imz[6]  = 32'h10;
        w[7]  = 32'h1422FFFE; exf[7]  = {6'd8,  5'd1, 5'd2, 5'd0,  2'b11, 1'b0}; ims[7]  = 32'hFFFFFFFE; imz[7]  = 32'h0000FFFE;
        w[8]  = 32'hC0E01234; exf[8]  = {6'd9,  5'd0, 5'd0, 5'd7,  2'b00, 1'b1}; ims[8]  = 32'h1234;     imz[8]  = 32'h1234;
        w[9]  = 32'hFC000000; exf[9]  = {6'h3F, 5'd0, 5'd0, 5'd0,  2'b00, 1'b0}; ims[9]  = 32'h0;        imz[9]  = 32'h0;
        w[10] = 32'h00000021; exf[10] = {6'h3F, 5'd0, 5'd0, 5'd0,  2'b00, 1'b0}; ims[10] = 32'h0;        imz[10] = 32'h0;
        w[11] = 32'h70000000; exf[11] = {6'h3F, 5'd0, 5'd0, 5'd0,  2'b00, 1'b0}; ims[11] = 32'h0;        imz[11] = 32'h0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            fetch_valid = 1'b1;
            fetch_instr = w[i];
            issue_ready = 1'b0;
            step();
            fetch_valid = 1'b0;
            #1;
            got = {operatorType, reg1, reg2, destreg, src_used, dest_used};
            checks++;
            if ({issue_valid, got, imm} !== {1'b1, exf[i], ims[i]})
                $display("FAIL decode_%0d word=%h got iv=%b fields=%h imm=%h want 1 %h %h",
                         i, w[i], issue_valid, got, imm, exf[i], ims[i]);
            else passed++;
            checks++;
            if (imm_z !== imz[i])
                $display("FAIL decode_zext_%0d word=%h got imm=%h want %h", i, w[i], imm_z, imz[i]);
            else passed++;
            issue_ready = 1'b1;
            step();
            issue_ready = 1'b0;
        end
        checks++;
        if (count !== 3'd0) $display("FAIL decode_drain count got %0d want 0", count);
        else passed++;
    endtask

    task automatic test_full();
        logic [31:0] wd [6];
        int exp_cnt;
        for (int i = 0; i < 6; i++) wd[i] = 32'hA000_0000 + 32'(i);
        do_reset();
        issue_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            fetch_valid = 1'b1;
            fetch_instr = wd[k-1];
            step();
            #1;
            exp_cnt = (k < 4) ? k : 4;
            checks++;
            if ({count, stall_cycles, fetch_ready, instr_out} !==
                {CW'(exp_cnt), CNTW'(k - 1), (k < 4), wd[0]})
                $display("FAIL full_push_%0d got cnt=%0d stall=%0d fr=%b head=%h want %0d %0d %b %h",
                         k, count, stall_cycles, fetch_ready, instr_out, exp_cnt, k - 1, (k < 4), wd[0]);
            else passed++;
        end
        fetch_valid = 1'b0;
        // 4 counted so far; 12 more back-pressured cycles must stop at all-ones
        for (int k = 0; k < 12; k++) step();
        checks++;
        if (stall_cycles !== 4'hF) $display("FAIL stall_saturate got %0d want 15", stall_cycles);
        else passed++;
        fetch_valid = 1'b1;
        fetch_instr = wd[5];
        issue_ready = 1'b1;
        #1;
        checks++;
        if (fetch_ready !== 1'b0) $display("FAIL full_pop_ready got %b want 0", fetch_ready);
        else passed++;
        step();
        fetch_valid = 1'b0;
        #1;
        checks++;
        if ({count, instr_out} !== {3'd3, wd[1]})
            $display("FAIL full_pop_nopush got cnt=%0d head=%h want 3 %h", count, instr_out, wd[1]);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (instr_out !== wd[k]) $display("FAIL full_drain_%0d got %h want %h", k, instr_out, wd[k]);
            else passed++;
            step();
        end
        checks++;
        if ({count, issue_valid, stall_cycles} !== {3'd0, 1'b0, 4'hF})
            $display("FAIL full_empty got cnt=%0d iv=%b stall=%0d want 0 0 15", count, issue_valid, stall_cycles);
        else passed++;
        issue_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            fetch_valid = 1'b1;
            fetch_instr = 32'hB000_0000 + 32'(k);
            step();
        end
        checks++;
        if ({count, stall_cycles} !== {3'd3, 4'd2})
            $display("FAIL flush_pre got cnt=%0d stall=%0d want 3 2", count, stall_cycles);
        else passed++;
        fetch_instr = 32'hDDDD_DDDD;
        issue_ready = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (issue_valid !== 1'b0) $display("FAIL flush_iv_comb got %b want 0", issue_valid);
        else passed++;
        step();
        flush = 1'b0;
        fetch_valid = 1'b0;
        issue_ready = 1'b0;
        #1;
        checks++;
        if ({count, issue_valid, stall_cycles} !== {3'd0, 1'b0, 4'd2})
            $display("FAIL flush_post got cnt=%0d iv=%b stall=%0d want 0 0 2", count, issue_valid, stall_cycles);
        else passed++;
        fetch_valid = 1'b1;
        fetch_instr = 32'hEEEE_0001;
        step();
        fetch_valid = 1'b0;
        #1;
        checks++;
        if ({count, instr_out} !== {3'd1, 32'hEEEE_0001})
            $display("FAIL flush_lost got cnt=%0d head=%h want 1 eeee0001", count, instr_out);
        else passed++;
        // reset while busy and flushing
        fetch_valid = 1'b1;
        fetch_instr = 32'hEEEE_0002;
        issue_ready = 1'b1;
        flush = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if ({issue_valid, fetch_ready} !== 2'b00)
            $display("FAIL midreset_hold got iv=%b fr=%b want 0 0", issue_valid, fetch_ready);
        else passed++;
        step();
        reset = 1'b0;
        flush = 1'b0;
        fetch_valid = 1'b0;
        issue_ready = 1'b0;
        #1;
        checks++;
        if ({count, stall_cycles, issue_valid} !== {3'd0, 4'd0, 1'b0})
            $display("FAIL midreset_post got cnt=%0d stall=%0d iv=%b want 0 0 0", count, stall_cycles, issue_valid);
        else passed++;
    endtask

    task automatic test_stream();
        logic [31:0] words [9];
        logic [31:0] q [$];
        int sent = 0;
        int rcv = 0;
        bit mpush, mpop;
        for (int i = 0; i < 9; i++) words[i] = 32'h5000_0000 + 32'(i * 17);
        do_reset();
        for (int cyc = 0; cyc < 300 && rcv < 9; cyc++) begin
            fetch_valid = (sent < 9);
            fetch_instr = (sent < 9) ? words[sent] : 32'h0;
            issue_ready = 1'($urandom_range(0, 1));
            #1;
            mpush = fetch_valid && (q.size() < DEPTH);
            mpop  = (q.size() != 0) && issue_ready;
            checks++;
            if ({fetch_ready, issue_valid, count} !== {(q.size() < DEPTH), (q.size() != 0), CW'(q.size())})
                $display("FAIL stream_ctl cyc=%0d got fr=%b iv=%b cnt=%0d want %b %b %0d",
                         cyc, fetch_ready, issue_valid, count, (q.size() < DEPTH), (q.size() != 0), q.size());
            else passed++;
            if (q.size() != 0) begin
                checks++;
                if (instr_out !== q[0])
                    $display("FAIL stream_order cyc=%0d got %h want %h", cyc, instr_out, q[0]);
                else passed++;
            end
            if (mpop) begin
                void'(q.pop_front());
                rcv++;
            end
            if (mpush) begin
                q.push_back(words[sent]);
                sent++;
            end
            step();
        end
        fetch_valid = 1'b0;
        issue_ready = 1'b0;
        checks++;
        if (rcv !== 9) $display("FAIL stream_complete got %0d want 9", rcv);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_decode();
        test_full();
        test_flush();
        test_stream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
